// File: rtl/ula_neander_seq_if.sv
// -----------------------------------------------------------------------------
// ula_neander_seq_if
//   Operand/result bundle between the Neander operand path and ula_neander_seq.
//   master : drives start, op, a, b; observes s, flags, busy, done
//   slave  : the ALU side (inputs/outputs mirrored)
// Signals
//   start  request, sampled on rising clk while busy=0
//   op     3-bit opcode
//   a, b   WIDTH-bit operands (AC, memory data)
//   s      registered result
//   flag_n/flag_z/flag_c  registered flags of the last completed op
//   busy   MUL in progress
//   done   one-cycle completion pulse
// -----------------------------------------------------------------------------
interface ula_neander_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  s, flag_n, flag_z, flag_c, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output s, flag_n, flag_z, flag_c, busy, done
  );
endinterface

// File: rtl/ula_neander_seq.sv
// -----------------------------------------------------------------------------
// ula_neander_seq
//   Registered ALU for the Neander datapath. Single-cycle ADD/OR/AND/NOT/SUB/
//   SHL/SHR complete on the edge that samples start; MUL runs WIDTH shift-add
//   steps on a 2*WIDTH product register. Result and N/Z/C flags are registered
//   and hold until the next completed op; done pulses for one cycle after each
//   completion.
// Ports
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  ula_neander_seq_if.slave (start/op/a/b in; s/flags/busy/done out)
// -----------------------------------------------------------------------------
module ula_neander_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ula_neander_seq_if.slave     bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifted right each step
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    z_d       = z_q;
    c_d       = c_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    res       = '0;
    res_c     = 1'b0;
    res_valid = 1'b0;

    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    // Borrow lands in the extra top bit when a < b.
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    if (state_q == ST_IDLE) begin
      if (bus.start) begin
        if (bus.op == OP_MUL) begin
          state_d  = ST_MUL;
          prod_d   = '0;
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d    = '0;
        end else begin
          res_valid = 1'b1;
          case (bus.op)
            OP_ADD: begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
            OP_OR:  begin res = bus.a | bus.b;   res_c = 1'b0;        end
            OP_AND: begin res = bus.a & bus.b;   res_c = 1'b0;        end
            OP_NOT: begin res = ~bus.a;          res_c = 1'b0;        end
            OP_SUB: begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
            OP_SHL: begin res = {bus.a[WIDTH-2:0], 1'b0}; res_c = bus.a[WIDTH-1]; end
            OP_SHR: begin res = {1'b0, bus.a[WIDTH-1:1]}; res_c = bus.a[0];       end
            default: begin res = '0; res_c = 1'b0; end
          endcase
        end
      end
    end else begin
      // One shift-add step per clock; start is ignored while here.
      prod_d   = prod_next;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d   = ST_IDLE;
        res       = prod_next[WIDTH-1:0];
        res_c     = |prod_next[2*WIDTH-1:WIDTH];
        res_valid = 1'b1;
      end
    end

    if (res_valid) begin
      s_d    = res;
      n_d    = res[WIDTH-1];
      z_d    = (res == '0);
      c_d    = res_c;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign bus.s      = s_q;
  assign bus.flag_n = n_q;
  assign bus.flag_z = z_q;
  assign bus.flag_c = c_q;
  assign bus.busy   = (state_q == ST_MUL);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_ula_neander_seq.sv
// -----------------------------------------------------------------------------
// tb_ula_neander_seq
//   Directed bench for ula_neander_seq at WIDTH=8: a vector table of single-op
//   transactions with hand-computed results, then hand-written sequences for
//   start-while-busy, reset mid-MUL and back-to-back single-cycle ops.
// -----------------------------------------------------------------------------
module tb_ula_neander_seq;

  localparam int W = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         n;
    logic         z;
    logic         c;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] last_s;

  ula_neander_seq_if #(.WIDTH(W)) bus ();

  ula_neander_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check latency, result and flags.
  task automatic do_op(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    @(negedge clk);
    bus.start = 1'b0;
    if (v.op == 3'b111) check({tag, "_hold_s"}, 32'(bus.s), 32'(last_s));
    lat = 0;
    while (bus.busy && lat < 50) begin
      check({tag, "_done_while_busy"}, 32'(bus.done), 32'd0);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, (v.op == 3'b111) ? W : 0);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_s"},    32'(bus.s),      32'(v.s));
    check({tag, "_n"},    32'(bus.flag_n), 32'(v.n));
    check({tag, "_z"},    32'(bus.flag_z), 32'(v.z));
    check({tag, "_c"},    32'(bus.flag_c), 32'(v.c));
    last_s = v.s;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t vecs[14];
    vec_t v;
    int   dones;
    int   overlap;

    //             op      a      b      s      n     z     c
    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0}; // ADD to sign
    vecs[1]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1}; // ADD carry out
    vecs[2]  = '{3'b100, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1}; // SUB borrow
    vecs[3]  = '{3'b100, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0}; // SUB no borrow
    vecs[4]  = '{3'b011, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0}; // NOT
    vecs[5]  = '{3'b110, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0, 1'b1}; // SHR
    vecs[6]  = '{3'b001, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0, 1'b0}; // OR
    vecs[7]  = '{3'b010, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0}; // AND zero
    vecs[8]  = '{3'b111, 8'h0C, 8'h0B, 8'h84, 1'b1, 1'b0, 1'b0}; // MUL 12*11=132
    vecs[9]  = '{3'b111, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1}; // MUL 0x100
    vecs[10] = '{3'b111, 8'h00, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0}; // MUL by zero
    vecs[11] = '{3'b111, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1}; // MUL 0xFE01
    vecs[12] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0}; // AND
    vecs[13] = '{3'b101, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1}; // SHL

    n_checks  = 0;
    n_errors  = 0;
    last_s    = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s",    32'(bus.s),      32'd0);
    check("rst_n",    32'(bus.flag_n), 32'd0);
    check("rst_z",    32'(bus.flag_z), 32'd0);
    check("rst_c",    32'(bus.flag_c), 32'd0);
    check("rst_busy", 32'(bus.busy),   32'd0);
    check("rst_done", 32'(bus.done),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // start held during a MUL with other ops: ignored, one done, result 3*5.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b111;
    bus.a     = 8'h03;
    bus.b     = 8'h05;
    dones   = 0;
    overlap = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.done && bus.busy) overlap++;
      if (i == 0) check("ign_hold_s", 32'(bus.s), 32'(last_s));
      bus.start = 1'b1;
      bus.op    = 3'(i);
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
      if (bus.done && bus.busy) overlap++;
      if (j == 0) begin
        check("ign_done", 32'(bus.done),   32'd1);
        check("ign_s",    32'(bus.s),      32'h0F);
        check("ign_c",    32'(bus.flag_c), 32'd0);
      end
    end
    check("ign_done_count", dones,   1);
    check("ign_overlap",    overlap, 0);
    last_s = 8'h0F;

    // Reset at MUL cycle 4: aborted, reset values, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b111;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_s",    32'(bus.s),      32'd0);
    check("mid_rst_n",    32'(bus.flag_n), 32'd0);
    check("mid_rst_z",    32'(bus.flag_z), 32'd0);
    check("mid_rst_c",    32'(bus.flag_c), 32'd0);
    check("mid_rst_busy", 32'(bus.busy),   32'd0);
    check("mid_rst_done", 32'(bus.done),   32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    last_s = '0;
    v = '{3'b000, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0};
    do_op("post_rst_add", v);

    // Back-to-back ADD, OR, AND: one result per clock.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'h10; bus.b = 8'h20;
    @(negedge clk);
    check("b2b_add_done", 32'(bus.done), 32'd1);
    check("b2b_add_s",    32'(bus.s),    32'h30);
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 8'h0F; bus.b = 8'hF0;
    @(negedge clk);
    check("b2b_or_done", 32'(bus.done),   32'd1);
    check("b2b_or_s",    32'(bus.s),      32'hFF);
    check("b2b_or_n",    32'(bus.flag_n), 32'd1);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h3C; bus.b = 8'h0F;
    @(negedge clk);
    check("b2b_and_done", 32'(bus.done),   32'd1);
    check("b2b_and_s",    32'(bus.s),      32'h0C);
    check("b2b_and_n",    32'(bus.flag_n), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    check("b2b_hold_s",   32'(bus.s),    32'h0C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
